// File: rtl/nano_rv32i_dbus.sv
// Data-side bus slave for the nano_rv32i core: byte-writable data RAM plus an
// MMIO block holding a GPIO register, a UART transmitter and a 64-bit cycle counter.
module nano_rv32i_dbus #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_i,
  output logic [31:0] d_data_o,
  input  logic [3:0]  d_rd_i,
  input  logic [3:0]  d_we_i,
  output logic [7:0]  gpio_o,
  output logic        uart_tx_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [7:0] OFF_GPIO      = 8'h00;
  localparam logic [7:0] OFF_UART_DATA = 8'h04;
  localparam logic [7:0] OFF_UART_STAT = 8'h08;
  localparam logic [7:0] OFF_CYC_LO    = 8'h0C;
  localparam logic [7:0] OFF_CYC_HI    = 8'h10;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] ram_idx;
  logic          is_mmio;
  logic [7:0]    mmio_off;

  uart_state_t   state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    tx_shift;
  logic          uart_busy;
  logic          uart_wr;
  logic          gpio_wr;
  logic          cyc_capture;

  logic [63:0]   cyc_cnt;
  logic [31:0]   cyc_hi;

  logic          unused_ok;

  assign ram_idx   = d_addr_i[AW+1:2];
  assign is_mmio   = d_addr_i[31];
  assign mmio_off  = d_addr_i[7:0];
  assign uart_busy = (state != IDLE);

  assign gpio_wr     = is_mmio && (mmio_off == OFF_GPIO) && d_we_i[0];
  assign uart_wr     = is_mmio && (mmio_off == OFF_UART_DATA) && d_we_i[0];
  assign cyc_capture = is_mmio && (mmio_off == OFF_CYC_LO) && (|d_rd_i);

  assign unused_ok = ^{d_addr_i[1:0], d_addr_i[30:8]};

  always_ff @(posedge clk_i) begin
    for (int unsigned n = 0; n < 4; n++) begin
      if (!is_mmio && d_we_i[n]) mem[ram_idx][8*n +: 8] <= d_data_i[8*n +: 8];
    end
  end

  always_comb begin
    d_data_o = '0;
    if (!is_mmio) begin
      d_data_o = mem[ram_idx];
    end else begin
      case (mmio_off)
        OFF_GPIO:      d_data_o = {24'b0, gpio_o};
        OFF_UART_STAT: d_data_o = {31'b0, uart_busy};
        OFF_CYC_LO:    d_data_o = cyc_cnt[31:0];
        OFF_CYC_HI:    d_data_o = cyc_hi;
        default:       d_data_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gpio_o  <= '0;
      cyc_cnt <= '0;
      cyc_hi  <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 64'd1;
      if (gpio_wr)     gpio_o <= d_data_i[7:0];
      if (cyc_capture) cyc_hi <= cyc_cnt[63:32];
    end
  end

  // tx_shift is consumed LSB first, so each bit boundary loads tx from bit 0 and shifts.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      tx_shift  <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (uart_wr) begin
            state     <= START;
            baud_cnt  <= '0;
            tx_shift  <= d_data_i[7:0];
            uart_tx_o <= 1'b0;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            state     <= DATA;
            uart_tx_o <= tx_shift[0];
            tx_shift  <= {1'b0, tx_shift[7:1]};
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state     <= STOP;
              uart_tx_o <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              uart_tx_o <= tx_shift[0];
              tx_shift  <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nano_rv32i_dbus.sv
// Directed scoreboard bench for nano_rv32i_dbus (DEPTH=16, CLKS_PER_BIT=4).
module tb_nano_rv32i_dbus;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CPB   = 4;

  localparam logic [31:0] A_GPIO   = 32'h8000_0000;
  localparam logic [31:0] A_UDATA  = 32'h8000_0004;
  localparam logic [31:0] A_USTAT  = 32'h8000_0008;
  localparam logic [31:0] A_CYC_LO = 32'h8000_000C;
  localparam logic [31:0] A_CYC_HI = 32'h8000_0010;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_data_i;
  logic [31:0] d_data_o;
  logic [3:0]  d_rd_i;
  logic [3:0]  d_we_i;
  logic [7:0]  gpio_o;
  logic        uart_tx_o;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  nano_rv32i_dbus #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .d_addr_i  (d_addr_i),
    .d_data_i  (d_data_i),
    .d_data_o  (d_data_o),
    .d_rd_i    (d_rd_i),
    .d_we_i    (d_we_i),
    .gpio_o    (gpio_o),
    .uart_tx_o (uart_tx_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=<queued value>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] rd, input logic [3:0] we);
    d_addr_i = a;
    d_data_i = d;
    d_rd_i   = rd;
    d_we_i   = we;
  endtask

  // Expected line level for cycle i of a frame carrying byte b.
  function automatic logic tx_level(input logic [7:0] b, input int i);
    int k;
    k = i / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic uart_frame(input logic [7:0] b, input bit poke);
    drive(A_UDATA, {24'hABCDEF, b}, 4'b0000, 4'b0001);
    push("uart_data_read", 32'h0);
    push("status_before_frame", 32'h0);
    #1 check(d_data_o);
    d_addr_i = A_USTAT;
    check(d_data_o);
    d_addr_i = A_UDATA;
    for (int i = 0; i < 10 * CPB; i++) begin
      push($sformatf("tx_c%0d", i), {31'b0, tx_level(b, i)});
      push($sformatf("busy_c%0d", i), 32'h1);
    end
    for (int i = 0; i < 8; i++) begin
      push($sformatf("tx_after_c%0d", i), 32'h1);
      push($sformatf("busy_after_c%0d", i), 32'h0);
    end
    @(negedge clk_i);
    drive(A_USTAT, 32'h0, 4'b0000, 4'b0000);
    for (int i = 0; i < 10 * CPB + 8; i++) begin
      #1;
      check({31'b0, uart_tx_o});
      check(d_data_o);
      if (poke && i == 20) drive(A_UDATA, 32'h0000_00FF, 4'b0000, 4'b0001);
      @(negedge clk_i);
      if (poke && i == 20) drive(A_USTAT, 32'h0, 4'b0000, 4'b0000);
    end
  endtask

  initial begin
    rst_n_i = 1'b0;
    drive(A_USTAT, 32'h0, 4'b0000, 4'b0000);

    // Reset state
    @(negedge clk_i);
    @(negedge clk_i);
    push("rst_gpio", 32'h0);
    push("rst_tx", 32'h1);
    push("rst_status", 32'h0);
    push("rst_cyc_lo", 32'h0);
    #1 check({24'b0, gpio_o});
    check({31'b0, uart_tx_o});
    check(d_data_o);
    d_addr_i = A_CYC_LO;
    #1 check(d_data_o);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Byte lanes and RAM wrap
    drive(32'h0000_0004, 32'h1234_5678, 4'b0000, 4'b1111);
    @(negedge clk_i);
    drive(32'h0000_0004, 32'hAABB_CCDD, 4'b0000, 4'b0101);
    @(negedge clk_i);
    drive(32'h0000_0004, 32'h0, 4'b1111, 4'b0000);
    push("ram_lanes", 32'h12BB_56DD);
    #1 check(d_data_o);
    d_addr_i = 32'h0000_0004 + 4 * DEPTH;
    push("ram_wrap", 32'h12BB_56DD);
    #1 check(d_data_o);

    // Simultaneous read/write shows the pre-edge value
    @(negedge clk_i);
    drive(32'h0000_0008, 32'h1111_1111, 4'b0000, 4'b1111);
    @(negedge clk_i);
    drive(32'h0000_0008, 32'h2222_2222, 4'b1111, 4'b1111);
    push("rw_same_pre", 32'h1111_1111);
    #1 check(d_data_o);
    @(negedge clk_i);
    drive(32'h0000_0008, 32'h0, 4'b0000, 4'b0000);
    push("rw_same_post", 32'h2222_2222);
    #1 check(d_data_o);

    // GPIO
    @(negedge clk_i);
    drive(A_GPIO, 32'hFFFF_FFA5, 4'b0000, 4'b0001);
    push("gpio_before_edge", 32'h0);
    #1 check({24'b0, gpio_o});
    @(negedge clk_i);
    drive(A_GPIO, 32'h0, 4'b1111, 4'b0000);
    push("gpio_out", 32'hA5);
    push("gpio_read", 32'h0000_00A5);
    #1 check({24'b0, gpio_o});
    check(d_data_o);
    drive(A_GPIO, 32'h0000_1200, 4'b0000, 4'b0010);
    @(negedge clk_i);
    drive(A_GPIO, 32'h0, 4'b0000, 4'b0000);
    push("gpio_lane1_ignored", 32'hA5);
    #1 check({24'b0, gpio_o});

    // Unmapped MMIO offset reads 0 and ignores writes
    drive(32'h8000_0020, 32'hDEAD_BEEF, 4'b0000, 4'b1111);
    @(negedge clk_i);
    drive(32'h8000_0020, 32'h0, 4'b1111, 4'b0000);
    push("mmio_unmapped", 32'h0);
    #1 check(d_data_o);
    @(negedge clk_i);

    // UART frame with a dropped mid-frame write
    uart_frame(8'h5A, 1'b1);

    // Cycle counter wrap and hi shadow
    drive(A_CYC_LO, 32'h0, 4'b1111, 4'b0000);
    force dut.cyc_cnt = 64'h0000_0000_FFFF_FFFE;
    push("cyc_lo_forced", 32'hFFFF_FFFE);
    #1 check(d_data_o);
    release dut.cyc_cnt;
    push("cyc_lo_released", 32'hFFFF_FFFE);
    #1 check(d_data_o);
    @(negedge clk_i);
    d_rd_i = 4'b0000;
    push("cyc_lo_plus1", 32'hFFFF_FFFF);
    #1 check(d_data_o);
    @(negedge clk_i);
    @(negedge clk_i);
    push("cyc_lo_wrapped", 32'h0000_0001);
    #1 check(d_data_o);
    d_addr_i = A_CYC_HI;
    push("cyc_hi_shadow_old", 32'h0);
    #1 check(d_data_o);
    drive(A_CYC_LO, 32'h0, 4'b0001, 4'b0000);
    @(negedge clk_i);
    drive(A_CYC_HI, 32'h0, 4'b0000, 4'b0000);
    push("cyc_hi_shadow_new", 32'h1);
    #1 check(d_data_o);
    @(negedge clk_i);

    // Mid-frame reset during DATA bit 3 of byte 0x00
    drive(A_UDATA, 32'h0, 4'b0000, 4'b0001);
    @(negedge clk_i);
    drive(A_USTAT, 32'h0, 4'b0000, 4'b0000);
    repeat (4 * CPB + 1) @(negedge clk_i);
    push("tx_bit3_low", 32'h0);
    #1 check({31'b0, uart_tx_o});
    rst_n_i = 1'b0;
    push("tx_async_reset", 32'h1);
    push("cyc_lo_in_reset", 32'h0);
    #1 check({31'b0, uart_tx_o});
    d_addr_i = A_CYC_LO;
    #1 check(d_data_o);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    d_addr_i = A_USTAT;
    push("status_after_reset", 32'h0);
    push("tx_after_reset", 32'h1);
    #1 check(d_data_o);
    check({31'b0, uart_tx_o});
    @(negedge clk_i);
    uart_frame(8'hC3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nano_rv32i_dbus.md
Name: nano_rv32i_dbus

Overview:
Data-side bus slave directly downstream of the nano_rv32i core data port (d_addr/d_data/d_rd/d_we). It decodes each access to one of two targets. Addresses with bit31=0 go to an on-chip byte-writable data RAM. Addresses with bit31=1 go to MMIO: an 8-bit GPIO output register, a UART transmitter and a 64-bit free-running cycle counter. Reads are combinational to match the core's single-cycle load timing. All writes and peripheral state update on the clock edge.

Parameters:
DEPTH, 1024, data RAM size in 32-bit words; power of two.
CLKS_PER_BIT, 434, clock cycles per UART bit (100 MHz / 230400 baud); minimum 2.

Ports:
clk_i  in  1  system clock; all state updates on the rising edge
rst_n_i  in  1  reset, asynchronous, active-low
d_addr_i  in  32  byte address from core
d_data_i  in  32  store data from core, already lane-aligned
d_data_o  out  32  load data to core, full word
d_rd_i  in  4  byte-lane read strobes; any bit set = read access
d_we_i  in  4  byte-lane write strobes
gpio_o  out  8  GPIO output register
uart_tx_o  out  1  UART serial line, idle high

Behaviour:
- Reset: clock and reset are clk_i and rst_n_i. Reset is asynchronous and active-low, as already decided.
- Reset values: gpio_o=0; uart_tx_o=1; UART FSM=IDLE; cycle counter=0; hi shadow=0. RAM contents are not reset.
- Decode uses word index = d_addr_i[31:2]; d_addr_i[1:0] is ignored.
- RAM region (bit31=0):
  - Index is d_addr_i[log2(DEPTH)+1:2]; higher bits are ignored, so the RAM aliases and wraps modulo DEPTH.
  - Read: d_data_o = mem[index] combinationally, independent of d_rd_i.
  - Write: at each edge, lane n is written when d_we_i[n]=1: mem[index][8n+7:8n] <= d_data_i[8n+7:8n]. Other lanes are untouched.
- MMIO map (bit31=1, offset = d_addr_i[7:0]; all other offsets read 0 and ignore writes):
  - 0x00 GPIO: read {24'b0,gpio_o}. Write with d_we_i[0]=1 loads d_data_i[7:0].
  - 0x04 UART_DATA: read 0. Write with d_we_i[0]=1 while IDLE starts a frame with byte d_data_i[7:0]. A write while busy is dropped.
  - 0x08 UART_STATUS: read {31'b0,busy}; busy=1 whenever FSM≠IDLE.
  - 0x0C CYC_LO: read counter[31:0]. An edge with any d_rd_i bit set at this offset captures counter[63:32] into the hi shadow.
  - 0x10 CYC_HI: read the hi shadow.
  - Writes to 0x08, 0x0C and 0x10 are ignored.
- Cycle counter: increments by 1 every cycle after reset; wraps from 2^64-1 to 0.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: accepting write → START at that edge; busy=1 from the next cycle.
  - START drives 0; DATA drives bits 0..7 LSB first; STOP drives 1.
  - Each state or bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter 0..CLKS_PER_BIT-1 and a 3-bit bit index.
  - STOP end → IDLE. A frame is 10*CLKS_PER_BIT cycles and back-to-back frames have no gap.
  - uart_tx_o is registered: it changes on the edge that enters a state or bit.
- Simultaneous read and write to the same address: d_data_o shows the pre-edge value; the new value is visible from the next cycle.
- d_rd_i=0 and d_we_i=0: d_data_o still reflects the decoded address; no side effects.
- Reset mid-frame: uart_tx_o returns to 1 immediately (asynchronously); the FSM returns to IDLE and the frame is lost.

Test Plan:
- Reset: hold rst_n_i=0 → gpio_o=0, uart_tx_o=1, STATUS reads 0, CYC_LO reads 0 while in reset.
- Byte lanes: write 0x12345678 to 0x4 with we=1111, then 0xAABBCCDD with we=0101 → read of 0x4 returns 0x12BB56DD. Read of 0x4+4*DEPTH returns the same value (wrap).
- GPIO: write 0xFFFFFFA5 to 0x80000000 with we=0001 → gpio_o=0xA5 next cycle; read returns 0x000000A5. A write with we=0010 leaves gpio_o unchanged.
- UART, CLKS_PER_BIT=4: write 0x5A to 0x80000004.
  - uart_tx_o sequence is 0, then 0,1,0,1,1,0,1,0, then 1, each level held 4 cycles (40 cycles total).
  - STATUS reads 1 for exactly those 40 cycles.
  - A second write of 0xFF mid-frame produces no second frame.
- Cycle counter: force the counter to 0x00000000_FFFFFFFE, read CYC_LO (captures shadow), then read CYC_HI 3 cycles later → CYC_HI=0x00000000 even though the counter has wrapped to 0x00000001_00000001.
- Mid-frame reset: assert rst_n_i during DATA bit 3 → uart_tx_o=1 without waiting for a clock edge. After release, STATUS=0 and a new write transmits a complete frame.
